// File: rtl/pulse_timer_if.sv
// Control/status bundle for pulse_timer: the master drives the controls, the slave
// (timer) returns the tick, busy flag, pulse count and active period.
interface pulse_timer_if #(
    parameter int unsigned CNT_W  = 27,
    parameter int unsigned PCNT_W = 8
) ();
    logic              en;
    logic              mode;
    logic              start;
    logic              period_ld;
    logic [CNT_W-1:0]  period_in;
    logic              pulse;
    logic              busy;
    logic [PCNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0]  period_q;

    modport master (
        output en, mode, start, period_ld, period_in,
        input  pulse, busy, pulse_cnt, period_q
    );

    modport slave (
        input  en, mode, start, period_ld, period_in,
        output pulse, busy, pulse_cnt, period_q
    );
endinterface

// File: rtl/pulse_timer.sv
// Periodic / one-shot tick generator with a shadowed, run-time programmable period
// and a wrap-around count of emitted pulses.
module pulse_timer #(
    parameter int unsigned CNT_W          = 27,
    parameter int unsigned DEFAULT_PERIOD = 100_000_000,
    parameter int unsigned PCNT_W         = 8
) (
    input logic          clk,
    input logic          rst_n,
    pulse_timer_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam int unsigned      DefPeff   = (DEFAULT_PERIOD == 0) ? 1 : DEFAULT_PERIOD;
    localparam logic [CNT_W-1:0] DefPeriod = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] DefCnt    = CNT_W'(DefPeff - 1);

    logic [CNT_W-1:0]  shadow_q, shadow_d;
    logic [CNT_W-1:0]  active_q, active_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pulse_q, pulse_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              mode_q;
    state_e            state_q, state_d;

    // Reload value P-1, with a programmed period of 0 behaving as 1.
    function automatic logic [CNT_W-1:0] peff_m1(input logic [CNT_W-1:0] p);
        return (p == '0) ? '0 : p - CNT_W'(1);
    endfunction

    always_comb begin
        // shadow_d doubles as the start source: it bypasses a same-cycle period load.
        shadow_d = bus.period_ld ? bus.period_in : shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        pcnt_d   = pcnt_q;
        state_d  = state_q;

        if (bus.mode != mode_q) begin
            state_d  = StIdle;
            active_d = shadow_q;
            cnt_d    = peff_m1(shadow_q);
        end else if (!mode_q) begin
            state_d = StIdle;
            if (!bus.en) begin
                active_d = shadow_q;
            end else if (bus.start) begin
                active_d = shadow_d;
                cnt_d    = peff_m1(shadow_d);
            end else if (cnt_q == '0) begin
                active_d = shadow_q;
                cnt_d    = peff_m1(shadow_q);
                pulse_d  = 1'b1;
                pcnt_d   = pcnt_q + PCNT_W'(1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    active_d = shadow_q;
                    cnt_d    = peff_m1(shadow_q);
                    if (bus.en && bus.start) begin
                        state_d  = StRun;
                        active_d = shadow_d;
                        cnt_d    = peff_m1(shadow_d);
                    end
                end
                StRun: begin
                    if (bus.en) begin
                        if (bus.start) begin
                            active_d = shadow_d;
                            cnt_d    = peff_m1(shadow_d);
                        end else if (cnt_q == '0) begin
                            state_d  = StIdle;
                            active_d = shadow_q;
                            cnt_d    = peff_m1(shadow_q);
                            pulse_d  = 1'b1;
                            pcnt_d   = pcnt_q + PCNT_W'(1);
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= DefPeriod;
            active_q <= DefPeriod;
            cnt_q    <= DefCnt;
            pulse_q  <= 1'b0;
            pcnt_q   <= '0;
            mode_q   <= 1'b0;
            state_q  <= StIdle;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            pcnt_q   <= pcnt_d;
            mode_q   <= bus.mode;
            state_q  <= state_d;
        end
    end

    assign bus.pulse     = pulse_q;
    assign bus.busy      = (state_q == StRun);
    assign bus.pulse_cnt = pcnt_q;
    assign bus.period_q  = active_q;

endmodule
